subtractor_seq: RTL and testbench

- Multi-cycle 32-bit two's-complement subtractor: diff = a - b, with borrow out and signed overflow flags.
- Computes one CHUNK-bit slice per clock, LSB slice first, using an internal carry register.
- Complements the combinational ripple adder in the lab3 datapath. It is used where a start/busy/done-handshaked subtract is needed for a compare-and-decrement loop in the ALU sequencer.

---
 rtl/subtractor_seq.sv | 92 +++++++++
 tb/tb_subtractor_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/subtractor_seq.sv
// Multi-cycle two's-complement subtractor: diff = a - b, one CHUNK-bit
// slice per clock, LSB first, with unsigned borrow and signed overflow.
module subtractor_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] lo_sum;
    logic [1:0]       hi_sum;
    logic [CHUNK-1:0] slice;
    logic             last;
    logic             accept;

    // Operands shift right each slice, so the active slice is always bits [CHUNK-1:0].
    // The MSB of the slice is added separately to expose the carry into it.
    assign lo_sum = {1'b0, a_q[CHUNK-2:0]} + {1'b0, ~b_q[CHUNK-2:0]}
                  + CHUNK'(carry);
    assign hi_sum = {1'b0, a_q[CHUNK-1]} + {1'b0, ~b_q[CHUNK-1]}
                  + {1'b0, lo_sum[CHUNK-1]};
    assign slice  = {hi_sum[0], lo_sum[CHUNK-2:0]};
    assign last   = (cnt == CW'(N - 1));
    assign accept = start && (state == IDLE || state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            overf <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                carry <= 1'b1;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        a_q   <= a_q >> CHUNK;
                        b_q   <= b_q >> CHUNK;
                        carry <= hi_sum[1];
                        cnt   <= cnt + 1'b1;
                        // New slice enters at the top; after N slices all are in place.
                        diff  <= WIDTH'({slice, diff} >> CHUNK);
                        if (last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            bout  <= ~hi_sum[1];
                            overf <= lo_sum[CHUNK-1] ^ hi_sum[1];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_subtractor_seq.sv
// Self-checking bench for subtractor_seq: directed cases plus random
// operands checked against plain-arithmetic subtraction.
module tb_subtractor_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        overf;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] last_d = '0;
    logic        last_b = 1'b0;
    logic        last_o = 1'b0;

    subtractor_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .diff(diff),
        .bout(bout),
        .overf(overf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives start in the current cycle (IDLE or DONE) and ends in the done cycle.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                         input bit pulse);
        logic [32:0] full;
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        full = {1'b0, x} - {1'b0, y};
        ed   = full[31:0];
        eb   = (x < y);
        eo   = ($signed(x) - $signed(y)) != ($signed({x[31], x}) - $signed({y[31], y}));
        eo   = (x[31] != y[31]) && (ed[31] != x[31]);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int i = 1; i <= 4; i++) begin
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            chk("bout_hold", 32'(bout), 32'(last_b));
            chk("overf_hold", 32'(overf), 32'(last_o));
            if (pulse && i == 2) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("busy_done", 32'(busy), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("diff", diff, ed);
        chk("bout", 32'(bout), 32'(eb));
        chk("overf", 32'(overf), 32'(eo));
        last_d = ed;
        last_b = eb;
        last_o = eo;
    endtask

    task automatic idle_chk();
        start = 1'b0;
        tick();
        chk("done_drop", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("diff_hold", diff, last_d);
        chk("bout_hold_idle", 32'(bout), 32'(last_b));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_diff"}, diff, 32'd0);
        chk({tag, "_bout"}, 32'(bout), 32'd0);
        chk({tag, "_overf"}, 32'(overf), 32'd0);
    endtask

    initial begin
        logic [31:0] x;
        logic [31:0] y;
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk_cleared("reset");
        reset = 1'b0;
        tick();
        chk_cleared("idle");

        do_op(32'd5, 32'd3, 1'b0);
        idle_chk();
        do_op(32'd3, 32'd5, 1'b0);
        idle_chk();
        do_op(32'h8000_0000, 32'h0000_0001, 1'b0);
        idle_chk();
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle_chk();
        do_op(32'h0100_0000, 32'h0000_0001, 1'b0);
        idle_chk();
        do_op(32'h0, 32'h0, 1'b0);
        idle_chk();

        do_op(32'h1234_5678, 32'h0000_1111, 1'b1);
        idle_chk();

        do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        do_op(32'd10, 32'd4, 1'b0);
        idle_chk();

        // Reset during cycle 3 of RUN.
        a = 32'h0000_0100;
        b = 32'h0000_0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_cleared("abort");
        last_d = '0;
        last_b = 1'b0;
        last_o = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("no_done_abort", 32'(done), 32'd0);
            tick();
        end
        do_op(32'd100, 32'd58, 1'b0);
        idle_chk();

        // Reset coincident with start wins.
        a = 32'd9;
        b = 32'd1;
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        chk_cleared("rst_start");
        last_d = '0;
        last_b = 1'b0;
        last_o = 1'b0;
        tick();
        chk("rst_start_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 24; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: y = x;
                1: x = {x[31], 31'h0};
                2: y = {~y[31], y[30:0]};
                default: ;
            endcase
            do_op(x, y, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) idle_chk();
        end
        idle_chk();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
